// File: rtl/efuse_prog_sequencer.sv
// eFuse program sequencer: qualifies a start request, latches a 32-bit fuse word and
// strobes fuse_prog once per set bit. Define EFUSE_START_CHECK_EN to add start-pulse width checking.
module efuse_prog_sequencer #(
  parameter int unsigned PROG_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic        clk_8M,
  input  logic        rst,
  input  logic        start_pulse,
  input  logic [31:0] prog_data,
  output logic [4:0]  fuse_addr,
  output logic        fuse_prog,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, QUAL, LOAD, PROG, GAP, DONE} state_t;

  localparam logic [7:0] PROG_LAST = 8'(PROG_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [4:0] ADDR_LAST = 5'd31;

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic [4:0]  addr_d;
  logic [31:0] data_q, data_d;
  logic        start_q;
  logic        start_edge;
  logic        cur_bit;
  logic        last_bit;
  logic        prog_d;

`ifdef EFUSE_START_CHECK_EN
  localparam logic [7:0] QUAL_OK  = 8'd7;
  localparam logic [7:0] QUAL_MAX = 8'd15;
  logic        err_q, err_d;
`endif

  assign start_edge = start_pulse & ~start_q;
  assign cur_bit    = data_q[fuse_addr];
  assign last_bit   = (fuse_addr == ADDR_LAST);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = fuse_addr;
    data_d  = data_q;
    prog_d  = 1'b0;
`ifdef EFUSE_START_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
`ifdef EFUSE_START_CHECK_EN
          state_d = QUAL;
          cnt_d   = 8'd1;
`else
          state_d = LOAD;
`endif
        end
      end
`ifdef EFUSE_START_CHECK_EN
      // Exactly seven high samples qualify; a pulse stuck high is aborted at fifteen.
      QUAL: begin
        if (start_pulse) begin
          if (cnt == QUAL_MAX - 8'd1) begin
            err_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end else begin
          cnt_d = 8'd0;
          if (cnt == QUAL_OK) begin
            state_d = LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      LOAD: begin
        data_d  = prog_data;
        addr_d  = 5'd0;
        cnt_d   = 8'd0;
        state_d = PROG;
      end
      PROG: begin
        if (cur_bit) begin
          if (cnt == PROG_LAST) begin
            cnt_d   = 8'd0;
            state_d = GAP;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end else if (last_bit) begin
          state_d = DONE;
        end else begin
          addr_d = fuse_addr + 5'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d = 8'd0;
          if (last_bit) begin
            state_d = DONE;
          end else begin
            addr_d  = fuse_addr + 5'd1;
            state_d = PROG;
          end
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = 5'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        addr_d  = 5'd0;
      end
    endcase
    // Strobe is registered: look ahead at the bit the next cycle will service.
    prog_d = (state_d == PROG) && ((state == LOAD) ? prog_data[0] : data_q[addr_d]);
  end

  always_ff @(posedge clk_8M or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      fuse_addr <= 5'd0;
      data_q    <= 32'd0;
      start_q   <= 1'b0;
      fuse_prog <= 1'b0;
`ifdef EFUSE_START_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      fuse_addr <= addr_d;
      data_q    <= data_d;
      start_q   <= start_pulse;
      fuse_prog <= prog_d;
`ifdef EFUSE_START_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
`ifdef EFUSE_START_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_efuse_prog_sequencer.sv
// Scoreboard bench for efuse_prog_sequencer: expected strobes, sequence lengths and
// error pulses are queued at stimulus time and retired by a negedge output monitor.
module tb_efuse_prog_sequencer;

  localparam int P = 16;
  localparam int G = 2;
`ifdef EFUSE_START_CHECK_EN
  localparam bit CHK   = 1'b1;
  localparam int HI_OK = 7;
`else
  localparam bit CHK   = 1'b0;
  localparam int HI_OK = 3;
`endif

  logic        clk_8M = 1'b0;
  logic        rst = 1'b0;
  logic        start_pulse = 1'b0;
  logic [31:0] prog_data = 32'd0;
  logic [4:0]  fuse_addr;
  logic        fuse_prog, busy, done, err;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_addr[$];
  int exp_len[$];
  int exp_err = 0;
  int ev_cnt  = 0;

  bit in_strobe = 0, addr_moved = 0, done_prev = 0, err_prev = 0;
  int strobe_addr = 0, strobe_len = 0, busy_cnt = 0;

  efuse_prog_sequencer #(.PROG_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk_8M      (clk_8M),
    .rst         (rst),
    .start_pulse (start_pulse),
    .prog_data   (prog_data),
    .fuse_addr   (fuse_addr),
    .fuse_prog   (fuse_prog),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk_8M = ~clk_8M;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: retires queued expectations as strobes, done and err appear.
  always @(negedge clk_8M) begin
    if (!rst) begin
      in_strobe  = 0;
      addr_moved = 0;
      done_prev  = 0;
      err_prev   = 0;
      strobe_len = 0;
      busy_cnt   = 0;
    end else begin
      if (done_prev) begin
        check_eq("after_done", {27'd0, done, busy, fuse_prog, err, 1'b0} | {27'd0, fuse_addr}, 0);
        done_prev = 0;
      end
      if (err_prev) begin
        check_eq("after_err", {err, busy, fuse_prog}, 0);
        err_prev = 0;
      end
      if (fuse_prog) begin
        check_eq("prog_busy_noerr", {busy, err}, 2'b10);
        if (!in_strobe) begin
          in_strobe   = 1;
          strobe_addr = fuse_addr;
          strobe_len  = 0;
          addr_moved  = 0;
        end else if (fuse_addr != 5'(strobe_addr)) begin
          addr_moved = 1;
        end
        strobe_len++;
      end else if (in_strobe) begin
        in_strobe = 0;
        if (exp_addr.size() == 0) begin
          check_eq("strobe_expected", 0, 1);
        end else begin
          check_eq("strobe_addr", strobe_addr, exp_addr.pop_front());
          check_eq("strobe_len", strobe_len, P);
          check_eq("strobe_addr_stable", addr_moved, 0);
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_len.size() == 0) check_eq("done_expected", 0, 1);
        else check_eq("seq_len", busy_cnt, exp_len.pop_front());
        busy_cnt  = 0;
        done_prev = 1;
        ev_cnt++;
      end
      if (err) begin
        check_eq("err_expected", (exp_err > 0) ? 1 : 0, 1);
        if (exp_err > 0) exp_err--;
        busy_cnt = 0;
        err_prev = 1;
        ev_cnt++;
      end
    end
  end

  task automatic run_seq(input logic [31:0] word, input int hi, input bit scramble, input bit retrig);
    bit accept = CHK ? (hi == 7) : 1'b1;
    int n1     = $countones(word);
    int qual   = CHK ? hi : 0;
    int ev0    = ev_cnt;
    int rt_left = 0;
    bit rt_done = 0;
    bit got     = 0;
    if (accept) begin
      for (int i = 0; i < 32; i++) if (word[i]) exp_addr.push_back(i);
      exp_len.push_back(qual + 1 + n1 * (P + G) + (32 - n1) + 1);
    end else begin
      exp_err++;
    end
    @(posedge clk_8M); #1;
    prog_data   = word;
    start_pulse = 1'b1;
    repeat (hi) @(posedge clk_8M);
    #1 start_pulse = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (ev_cnt != ev0) begin
        got = 1;
        break;
      end
      @(posedge clk_8M); #1;
      if (scramble && c == 2) prog_data = ~word ^ $urandom();
      if (retrig) begin
        if (rt_left > 0) begin
          rt_left--;
          if (rt_left == 0) start_pulse = 1'b0;
        end else if (!rt_done && fuse_addr == 5'd3 && fuse_prog) begin
          rt_done     = 1;
          start_pulse = 1'b1;
          rt_left     = HI_OK;
        end
      end
    end
    start_pulse = 1'b0;
    check_eq("seq_finished", got, 1);
    repeat (4) @(posedge clk_8M);
  endtask

  task automatic reset_mid();
    int seen = 0;
    bit hit  = 0;
    @(posedge clk_8M); #1;
    prog_data   = 32'h0000_0020;
    start_pulse = 1'b1;
    repeat (HI_OK) @(posedge clk_8M);
    #1 start_pulse = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(posedge clk_8M); #1;
      if (fuse_prog && fuse_addr == 5'd5) begin
        seen++;
        if (seen == 7) hit = 1;
      end
    end
    check_eq("rst_reached_addr5", hit, 1);
    @(posedge clk_8M); #2;
    rst = 1'b0;
    #1;
    check_eq("rst_mid_prog", fuse_prog, 0);
    check_eq("rst_mid_outs", {busy, done, err, fuse_addr}, 0);
    repeat (3) @(posedge clk_8M);
    #1 rst = 1'b1;
    repeat (30) @(posedge clk_8M);
    #1;
    check_eq("post_rst_idle", {busy, fuse_prog, fuse_addr}, 0);
  endtask

  initial begin
    #12;
    check_eq("reset_addr", fuse_addr, 0);
    check_eq("reset_outs", {fuse_prog, busy, done, err}, 0);
    @(posedge clk_8M); #1 rst = 1'b1;

    run_seq(32'h8000_0000, HI_OK, 0, 0);
    run_seq(32'h0000_0001, HI_OK, 0, 0);
    run_seq(32'h0000_0000, HI_OK, 0, 0);
    run_seq(32'hFFFF_FFFF, HI_OK, 0, 0);
    run_seq(32'hA5C3_0F96, HI_OK, 1, 0);
    run_seq(32'h0000_000F, HI_OK, 0, 1);
`ifdef EFUSE_START_CHECK_EN
    run_seq(32'h0000_0001, 5, 0, 0);
    run_seq(32'h0000_0001, 16, 0, 0);
    run_seq(32'h0000_0003, 8, 0, 0);
`endif
    reset_mid();
    run_seq(32'h8000_0001, HI_OK, 0, 0);

    repeat (20) @(posedge clk_8M);
    #1;
    check_eq("queue_strobes_empty", exp_addr.size(), 0);
    check_eq("queue_len_empty", exp_len.size(), 0);
    check_eq("queue_err_empty", exp_err, 0);
    check_eq("final_idle", {busy, fuse_prog, err}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/efuse_prog_sequencer.md
EFUSE_PROG_SEQUENCER -- requirements
Module: efuse_prog_sequencer

Interface
REQ-001 SHALL provide parameter PROG_CYCLES, default 16, as the fuse_prog high time per programmed bit in clk_8M cycles (2 us), legal range 1..255.
REQ-002 SHALL provide parameter GAP_CYCLES, default 2, as the fuse_prog low time after each programmed bit, legal range 1..15.
REQ-003 SHALL have port clk_8M, input, 1, 8 MHz system clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start_pulse, input, 1, fixed-width start request from the start generator, synchronous to clk_8M.
REQ-006 SHALL have port prog_data, input, 32, fuse word; bit i=1 means blow fuse i.
REQ-007 SHALL have port fuse_addr, output, 5, index of the fuse being processed.
REQ-008 SHALL have port fuse_prog, output, 1, registered program strobe to the eFuse macro.
REQ-009 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1, one-cycle start-qualification error pulse.

Function
REQ-012 SHALL implement states IDLE, QUAL, LOAD, PROG, GAP, DONE.
REQ-013 SHALL detect a start edge E on the first clk_8M edge that samples start_pulse=1 while the registered previous sample was 0.
REQ-014 IDLE: on E, SHALL go to QUAL if pulse checking is compiled in, else to LOAD; otherwise SHALL stay in IDLE.
REQ-015 QUAL: SHALL count high samples including E; on the first low sample, count==7 SHALL go to LOAD, and any other count SHALL pulse err for one cycle and go to IDLE.
REQ-016 QUAL: count reaching 15 while start_pulse is still high SHALL pulse err and go to IDLE, and the remaining high level SHALL NOT retrigger.
REQ-017 LOAD: SHALL take one cycle, latch prog_data into an internal register, and set fuse_addr=0; later prog_data changes SHALL have no effect.
REQ-018 PROG, latched bit[fuse_addr]=1: fuse_prog SHALL be high for exactly PROG_CYCLES consecutive cycles, followed by GAP.
REQ-019 PROG, latched bit[fuse_addr]=0: SHALL spend one cycle with fuse_prog low, then advance fuse_addr, with no GAP.
REQ-020 GAP: fuse_prog SHALL be low for exactly GAP_CYCLES cycles; it SHALL then advance fuse_addr and return to PROG, or go to DONE after address 31.
REQ-021 Skipped bit 31 SHALL go directly to DONE.
REQ-022 fuse_addr SHALL be stable for the whole strobe and gap of its bit; it SHALL NOT wrap past 31 within one sequence.
REQ-023 DONE: done SHALL be high for one cycle, then the state SHALL return to IDLE with fuse_addr=0.
REQ-024 start_pulse edges in any state other than IDLE SHALL be ignored.
REQ-025 fuse_prog and err SHALL never be high in the same cycle, and fuse_prog SHALL be low in every state except PROG.
REQ-026 Total sequence length after LOAD SHALL be N1*(PROG_CYCLES+GAP_CYCLES)+(32-N1)+1 cycles, where N1 is the number of ones.

Reset
REQ-027 rst low SHALL immediately force IDLE, fuse_addr=0, fuse_prog=0, busy=0, done=0, err=0, and clear all counters and the latched word.
REQ-028 Reset assertion mid-PROG SHALL drop fuse_prog asynchronously, and no sequence SHALL resume after release.
REQ-029 The first start edge SHALL be detectable one cycle after rst release, with the previous-sample register reset to 0.

Configuration
REQ-030 Macro EFUSE_START_CHECK_EN defined: QUAL SHALL be compiled in and REQ-015/016 SHALL apply.
REQ-031 Macro EFUSE_START_CHECK_EN undefined: QUAL logic SHALL be absent, err SHALL be tied 0, and E SHALL go directly to LOAD.

Verification
REQ-032 Check enabled, 7-cycle start_pulse, prog_data=32'h0000_0001 -> one 16-cycle fuse_prog at fuse_addr=0, 2-cycle gap, 31 skip cycles, done 1 cycle; busy spans the whole sequence.
REQ-033 Check enabled, 5-cycle start_pulse -> err pulse 1 cycle, fuse_prog never high, busy low after return to IDLE.
REQ-034 prog_data=32'hFFFF_FFFF, defaults -> 32 strobes of 16 cycles each on addresses 0..31, 576 cycles from LOAD exit to DONE.
REQ-035 Second start_pulse during PROG at fuse_addr=3 -> ignored; exactly one done.
REQ-036 rst low in the 8th cycle of strobe at fuse_addr=5 -> fuse_prog low the same cycle, all outputs at reset values, no activity until the next start.
REQ-037 Check disabled, 3-cycle start_pulse, prog_data=32'h8000_0000 -> accepted, single strobe at fuse_addr=31, then DONE, err stays 0.
